addsub_seq: RTL and testbench
=============================

Name: addsub_seq

Overview:
- Parametrised, multi-cycle signed/unsigned add/subtract unit for the datapath; successor to the fixed 64-bit combinational subtractor.
- Processes operands CHUNK bits per cycle, LSB chunk first, so wide operands stay off the critical path.
- Valid/ready handshake on input and output, so the ALU issue logic can stall on it.
- Reports carry/borrow, signed overflow and zero flags.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 16, bits processed per cycle; NCH = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  unit can accept; high only in IDLE
- a  input  WIDTH  minuend/addend
- b  input  WIDTH  subtrahend/addend
- op_sub  input  1  0: a+b+c_in; 1: a-b-c_in (c_in = borrow-in)
- c_in  input  1  carry-in (add) / borrow-in (sub)
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference, modulo 2^WIDTH
- carry_out  output  1  add: carry out of MSB; sub: borrow (1 when unsigned a < b + c_in)
- overflow  output  1  two's-complement signed overflow
- zero  output  1  result == 0

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high. On reset:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - result = 0; carry_out = 0; overflow = 0; zero = 0; chunk counter = 0.
  - Reset overrides everything, including an operation in flight; the partial result is discarded and no out_valid is produced.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready at edge T:
    - latch a; latch b_eff = op_sub ? ~b : b; latch op_sub.
    - carry register = op_sub ? ~c_in : c_in.
    - counter = 0; go to CALC.
  - CALC: each cycle adds chunk[counter] of a, b_eff and carry; writes the CHUNK-bit sum into result[counter*CHUNK +: CHUNK]; updates carry; increments counter. When counter == NCH-1, go to DONE on the same edge.
  - DONE: out_valid = 1; result and flags held stable. On out_valid & out_ready, go to IDLE. in_ready is not asserted in the same cycle (no bypass).
- Latency:
  - Operation accepted at edge T; out_valid is high after edge T+NCH.
  - Minimum issue interval is NCH+2 cycles.
- Flags (registered on the final CALC edge):
  - carry_out = op_sub ? ~carry_final : carry_final.
  - overflow = (a[MSB] == b_eff[MSB]) & (result[MSB] != a[MSB]).
  - zero = (full result == 0).
- Boundary behaviour:
  - in_valid while not IDLE: ignored; the source must hold the operands.
  - out_ready low: DONE is held indefinitely and outputs stay stable.
  - out_ready high before DONE: no effect.
  - CHUNK == WIDTH: single CALC cycle (NCH = 1).
  - Operand inputs are sampled only on the accept edge; later changes have no effect.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined:
  - When overflow = 1, result is clamped to the signed extreme in the direction of a's sign: 0x7FF..F if a[MSB] = 0, else 0x800..0.
  - overflow still reports 1; zero is computed on the clamped value.
  - The clamp is applied on the final CALC edge, so latency is unchanged.
- Not defined: result wraps modulo 2^WIDTH; no clamp logic is built.

Test Plan:
- WIDTH=64, CHUNK=16, reset: rst high 2 cycles -> in_ready=1, out_valid=0, all outputs 0. Then sub with a=5, b=3, c_in=0 -> out_valid after exactly 4 cycles; result=2, carry_out=0, overflow=0, zero=0.
- Borrow across chunks: sub with a=0x0000_0000_0001_0000, b=1 -> result=0x0000_0000_0000_FFFF, carry_out=0. Then sub with a=0, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF, carry_out=1, overflow=0.
- Signed overflow: add with a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, overflow=1. With ADDSUB_SATURATE_EN -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Carry-in and zero: add with a=0xFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 -> result=0, carry_out=1, zero=1. Sub with a=7, b=6, c_in=1 -> result=0, zero=1, carry_out=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, and an in_valid pulse is ignored. Raise out_ready -> IDLE next cycle; a new op is then accepted.
- Reset mid-op: assert rst on the 2nd CALC cycle -> next cycle shows IDLE with reset outputs and no out_valid. A following op (a=10, b=4, sub) gives result=6.

Source files
------------

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle chunked add/subtract unit with valid/ready handshake and carry/overflow/zero flags.
// Ports: clk, rst (sync, active-high); in_valid/in_ready accept a, b, op_sub, c_in;
// out_valid/out_ready hand back result, carry_out (borrow on subtract), overflow and zero.
// Optional macro ADDSUB_SATURATE_EN clamps an overflowing result to the signed extreme.
module addsub_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, res_d;
  logic             sub_q, carry_q, carry_out_q, overflow_q, zero_q;
  logic [CW-1:0]    cnt_q;
  logic [CHUNK:0]   sum;
  logic [31:0]      base;
  logic             last, ovf_d;
  assign last = cnt_q == CW'(NCH - 1);
  // b_q already holds ~b and carry_q ~c_in for subtraction, so every chunk is a plain add.
  always_comb begin
    base = 32'(cnt_q) * 32'(CHUNK);
    sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]} + {{CHUNK{1'b0}}, carry_q};
    res_d = result_q;
    res_d[base +: CHUNK] = sum[CHUNK-1:0];
    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (res_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
    if (last && ovf_d) res_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= op_sub ? ~b : b;
          sub_q   <= op_sub;
          carry_q <= op_sub ? ~c_in : c_in;
          cnt_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          result_q <= res_d;
          carry_q  <= sum[CHUNK];
          cnt_q    <= cnt_q + CW'(1);
          if (last) begin
            carry_out_q <= sub_q ^ sum[CHUNK];
            overflow_q  <= ovf_d;
            zero_q      <= res_d == '0;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: randomized and directed checks of addsub_seq against an arithmetic reference model.
module tb_addsub_seq;
  localparam int NCH = 4;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, op_sub = 1'b0, c_in = 1'b0, out_ready = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        in_ready, out_valid, carry_out, overflow, zero;
  logic [63:0] result;
  logic        in_valid2 = 1'b0, op_sub2 = 1'b0, c_in2 = 1'b0, out_ready2 = 1'b0;
  logic [31:0] a2 = '0, b2 = '0;
  logic        in_ready2, out_valid2, carry_out2, overflow2, zero2;
  logic [31:0] result2;
  int          errs = 0, checks = 0;
  logic [63:0] o_res;
  logic        o_co, o_ov, o_z;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .op_sub(op_sub), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  addsub_seq #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .op_sub(op_sub2), .c_in(c_in2), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .carry_out(carry_out2), .overflow(overflow2), .zero(zero2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {zero, overflow, carry_out, result} computed from true integer arithmetic.
  function automatic logic [66:0] model(input logic [63:0] av, bv, input logic s, ci);
    logic signed [65:0] sr;
    logic [64:0] ur;
    logic [63:0] r;
    logic co, ov;
    sr = s ? $signed({{2{av[63]}}, av}) - $signed({{2{bv[63]}}, bv}) - $signed(66'(ci))
           : $signed({{2{av[63]}}, av}) + $signed({{2{bv[63]}}, bv}) + $signed(66'(ci));
    ur = {1'b0, av} + {1'b0, bv} + 65'(ci);
    co = s ? ({1'b0, av} < {1'b0, bv} + 65'(ci)) : ur[64];
    ov = sr != {{2{sr[63]}}, sr[63:0]};
    r = sr[63:0];
`ifdef ADDSUB_SATURATE_EN
    if (ov) r = sr[65] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    return {r == 64'd0, ov, co, r};
  endfunction

  task automatic do_op(input logic [63:0] av, bv, input logic s, ci, input int hold);
    logic [66:0] e;
    int cyc;
    e = model(av, bv, s, ci);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    a = av; b = bv; op_sub = s; c_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    op_sub = 1'($urandom); c_in = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(NCH));
    check("result", result, e[63:0]);
    check("carry_out", 64'(carry_out), 64'(e[64]));
    check("overflow", 64'(overflow), 64'(e[65]));
    check("zero", 64'(zero), 64'(e[66]));
    o_res = result; o_co = carry_out; o_ov = overflow; o_z = zero;
    for (int i = 0; i < hold; i++) begin
      if (i == hold / 2) begin
        in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_result", result, e[63:0]);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_flags", {61'd0, carry_out, overflow, zero}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(64'd5, 64'd3, 1'b1, 1'b0, 0);
    check("sub5_3", o_res, 64'd2);
    check("sub5_3_flags", {61'd0, o_co, o_ov, o_z}, 64'd0);
    do_op(64'h0000_0000_0001_0000, 64'd1, 1'b1, 1'b0, 0);
    check("borrow_chunk", o_res, 64'h0000_0000_0000_FFFF);
    check("borrow_chunk_co", 64'(o_co), 64'd0);
    do_op(64'd0, 64'd1, 1'b1, 1'b0, 0);
    check("zero_minus_one", o_res, 64'hFFFF_FFFF_FFFF_FFFF);
    check("zero_minus_one_co_ov", {62'd0, o_co, o_ov}, 64'd2);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
`ifdef ADDSUB_SATURATE_EN
    check("ovf_result", o_res, 64'h7FFF_FFFF_FFFF_FFFF);
`else
    check("ovf_result", o_res, 64'h8000_0000_0000_0000);
`endif
    check("ovf_flag", 64'(o_ov), 64'd1);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 0);
    check("cin_wrap", o_res, 64'd0);
    check("cin_wrap_co_z", {62'd0, o_co, o_z}, 64'd3);
    do_op(64'd7, 64'd6, 1'b1, 1'b1, 0);
    check("bin_zero", o_res, 64'd0);
    check("bin_zero_co_z", {62'd0, o_co, o_z}, 64'd1);
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 10);
    check("backpressure_res", o_res, 64'h2222_2222_2222_2211);
    do_op(64'd100, 64'd1, 1'b0, 1'b0, 0);
    check("after_bp", o_res, 64'd101);

    a = 64'd99; b = 64'd1; op_sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_flags", {61'd0, carry_out, overflow, zero}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_no_valid", 64'(out_valid), 64'd0);
    end
    do_op(64'd10, 64'd4, 1'b1, 1'b0, 0);
    check("post_rst_sub", o_res, 64'd6);

    for (int n = 0; n < 40; n++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 8 == 1) ra = 64'h8000_0000_0000_0000;
      if (n % 8 == 2) rb = ra;
      if (n % 8 == 3) rb = 64'hFFFF_FFFF_FFFF_FFFF;
      do_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    for (int n = 0; n < 12; n++) begin
      logic [63:0] u;
      logic signed [63:0] sv;
      logic [31:0] er;
      int cyc;
      a2 = $urandom; b2 = $urandom; op_sub2 = 1'($urandom); c_in2 = 1'($urandom);
      if (n == 0) begin a2 = 32'h7FFF_FFFF; b2 = 32'd1; op_sub2 = 1'b0; c_in2 = 1'b0; end
      if (n == 1) begin a2 = 32'h8000_0000; b2 = 32'd1; op_sub2 = 1'b1; c_in2 = 1'b0; end
      u = op_sub2 ? {32'd0, a2} - {32'd0, b2} - 64'(c_in2) : {32'd0, a2} + {32'd0, b2} + 64'(c_in2);
      sv = op_sub2 ? $signed({{32{a2[31]}}, a2}) - $signed({{32{b2[31]}}, b2}) - $signed(64'(c_in2))
                   : $signed({{32{a2[31]}}, a2}) + $signed({{32{b2[31]}}, b2}) + $signed(64'(c_in2));
      er = u[31:0];
`ifdef ADDSUB_SATURATE_EN
      if (sv != {{32{sv[31]}}, sv[31:0]}) er = sv[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      cyc = 0;
      while (!out_valid2 && cyc < 10) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("w32_latency", 64'(cyc), 64'd1);
      check("w32_result", 64'(result2), 64'(er));
      check("w32_carry", 64'(carry_out2), 64'(u[32]));
      check("w32_overflow", 64'(overflow2), 64'(sv != {{32{sv[31]}}, sv[31:0]}));
      check("w32_zero", 64'(zero2), 64'(er == 32'd0));
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
